// File: rtl/sfp_pkg.sv
// Shared slf-format definitions for the streaming accumulator.
// Fields: [25] sign, [24:17] biased exponent, [16:0] fraction with a hidden leading one.
package sfp_pkg;
    localparam int SFP_W   = 26;
    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 17;
    localparam int BIAS    = 127;
    localparam int GUARD_W = 3;
    localparam int MANT_W  = 1 + FRAC_W + GUARD_W;
    localparam int SGN_B   = SFP_W - 1;

    typedef enum logic [1:0] {IDLE, ALIGN, ADD, NORM} state_t;

    localparam logic [SFP_W-1:0] SFP_ZERO    = '0;
    localparam logic [SFP_W-1:0] SFP_MAX_POS = {1'b0, 8'd254, {FRAC_W{1'b1}}};
    localparam logic [SFP_W-1:0] SFP_MAX_NEG = {1'b1, 8'd254, {FRAC_W{1'b1}}};

    function automatic logic [EXP_W-1:0] exp_of(input logic [SFP_W-1:0] v);
        return v[SFP_W-2 -: EXP_W];
    endfunction

    // A zero exponent means the value is zero, whatever the fraction holds.
    function automatic logic [MANT_W-1:0] mant_of(input logic [SFP_W-1:0] v);
        return (exp_of(v) == '0) ? '0 : {1'b1, v[FRAC_W-1:0], {GUARD_W{1'b0}}};
    endfunction
endpackage

// File: rtl/sfp_acc_fifo.sv
// Show-ahead synchronous FIFO: rdata presents the head entry while not empty.
module sfp_acc_fifo #(
    parameter int W  = 26,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         rd,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wp, rp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (rd) rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/sfp_acc.sv
// Group accumulator for slf products: folds LEN products through IDLE/ALIGN/ADD/NORM.
// Build option SFP_ACC_RND_EN selects round-to-nearest-even instead of truncation.
module sfp_acc
    import sfp_pkg::*;
#(
    parameter int LEN     = 16,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [SFP_W-1:0] i_dat,
    output logic             o_vld,
    output logic [SFP_W-1:0] o_dat,
    output logic             o_ovf
);
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    state_t             state, nxt;
    logic               pop, wr, full, empty;
    logic [SFP_W-1:0]   head, acc, opnd, res;
    logic [CW-1:0]      cnt;
    logic               done;

    assign pop  = (state == IDLE) && !empty;
    assign wr   = i_req && (!full || pop);
    assign done = (cnt == CW'(LEN - 1));

    sfp_acc_fifo #(.W(SFP_W), .AW(FIFO_AW)) u_fifo (
        .clk(clk), .rst(rst), .wr(wr), .wdata(i_dat), .rd(pop),
        .rdata(head), .full(full), .empty(empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!empty) nxt = ALIGN;
            ALIGN:   nxt = ADD;
            ADD:     nxt = NORM;
            NORM:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // ALIGN: the operand with the smaller exponent is shifted down to match.
    logic [EXP_W-1:0]  ea, eb, diff;
    logic [MANT_W-1:0] ma, mb, sml_pre, sml;
    logic              a_ge;

    always_comb begin
        ea      = exp_of(acc);
        eb      = exp_of(opnd);
        ma      = mant_of(acc);
        mb      = mant_of(opnd);
        a_ge    = (ea >= eb);
        diff    = a_ge ? (ea - eb) : (eb - ea);
        sml_pre = a_ge ? mb : ma;
        sml     = (diff >= EXP_W'(MANT_W)) ? '0 : (sml_pre >> diff);
    end

    logic [MANT_W-1:0] big_r, sml_r;
    logic [EXP_W-1:0]  exp_r;
    logic              sb_r, ss_r;

    // ADD: with equal exponents the aligned operand can be the larger magnitude.
    logic [MANT_W:0]   sum_n, sum_r;
    logic              sgn_n, sgn_r;

    always_comb begin
        if (sb_r == ss_r) begin
            sum_n = {1'b0, big_r} + {1'b0, sml_r};
            sgn_n = sb_r;
        end else if (big_r >= sml_r) begin
            sum_n = {1'b0, big_r - sml_r};
            sgn_n = sb_r;
        end else begin
            sum_n = {1'b0, sml_r - big_r};
            sgn_n = ss_r;
        end
    end

    // NORM: bring the leading one to the hidden-bit position, then pack.
    logic [4:0]              lead, sh;
    logic [MANT_W-1:0]       n;
    logic                    drop;
    logic signed [EXP_W+1:0] e;
    logic [FRAC_W-1:0]       frac;
    logic                    unused;
`ifdef SFP_ACC_RND_EN
    logic                    inc;
    logic [MANT_W-GUARD_W:0] rnd;
`endif

    always_comb begin
        lead = '0;
        for (int i = 0; i <= MANT_W; i++)
            if (sum_r[i]) lead = 5'(i);
        sh   = '0;
        drop = 1'b0;
        if (sum_r[MANT_W]) begin
            n    = sum_r[MANT_W:1];
            drop = sum_r[0];
            e    = $signed({2'b00, exp_r}) + 10'sd1;
        end else begin
            sh = 5'(MANT_W - 1) - lead;
            n  = sum_r[MANT_W-1:0] << sh;
            e  = $signed({2'b00, exp_r}) - $signed({5'b00000, sh});
        end
`ifdef SFP_ACC_RND_EN
        inc  = n[GUARD_W-1] & (n[GUARD_W-2] | n[0] | drop | n[GUARD_W]);
        rnd  = {1'b0, n[MANT_W-1:GUARD_W]} + {{(MANT_W-GUARD_W){1'b0}}, inc};
        if (rnd[MANT_W-GUARD_W]) e = e + 10'sd1;
        frac = rnd[FRAC_W-1:0];
`else
        frac = n[MANT_W-2:GUARD_W];
`endif
        unused = ^{n[GUARD_W-1:0], drop, e[EXP_W+1:EXP_W]};
        if (sum_r == '0 || e < 10'sd1) res = SFP_ZERO;
        else if (e > 10'sd254)         res = sgn_r ? SFP_MAX_NEG : SFP_MAX_POS;
        else                           res = {sgn_r, e[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= SFP_ZERO;
            opnd  <= SFP_ZERO;
            big_r <= '0;
            sml_r <= '0;
            exp_r <= '0;
            sb_r  <= 1'b0;
            ss_r  <= 1'b0;
            sum_r <= '0;
            sgn_r <= 1'b0;
            cnt   <= '0;
            o_vld <= 1'b0;
            o_dat <= SFP_ZERO;
            o_ovf <= 1'b0;
        end else begin
            o_vld <= 1'b0;
            if (i_req && full && !pop) o_ovf <= 1'b1;
            case (state)
                IDLE:  if (pop) opnd <= head;
                ALIGN: begin
                    big_r <= a_ge ? ma : mb;
                    sml_r <= sml;
                    exp_r <= a_ge ? ea : eb;
                    sb_r  <= a_ge ? acc[SGN_B]  : opnd[SGN_B];
                    ss_r  <= a_ge ? opnd[SGN_B] : acc[SGN_B];
                end
                ADD: begin
                    sum_r <= sum_n;
                    sgn_r <= sgn_n;
                end
                NORM: begin
                    if (done) begin
                        acc   <= SFP_ZERO;
                        cnt   <= '0;
                        o_vld <= 1'b1;
                        o_dat <= res;
                    end else begin
                        acc <= res;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sfp_acc.sv
// Directed bench for sfp_acc: three instances cover LEN=4, LEN=2 and a shallow-FIFO LEN=16 build.
module tb_sfp_acc;
    localparam logic [25:0] ONE  = 26'h0FE0000;
    localparam logic [25:0] MONE = 26'h2FE0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
    logic [25:0] dat_a = '0, dat_b = '0, dat_c = '0;
    logic        vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c;
    logic [25:0] out_a, out_b, out_c;
    int          cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    sfp_acc #(.LEN(4), .FIFO_AW(4)) u_a (.clk(clk), .rst(rst), .i_req(req_a), .i_dat(dat_a),
        .o_vld(vld_a), .o_dat(out_a), .o_ovf(ovf_a));
    sfp_acc #(.LEN(2), .FIFO_AW(4)) u_b (.clk(clk), .rst(rst), .i_req(req_b), .i_dat(dat_b),
        .o_vld(vld_b), .o_dat(out_b), .o_ovf(ovf_b));
    sfp_acc #(.LEN(16), .FIFO_AW(2)) u_c (.clk(clk), .rst(rst), .i_req(req_c), .i_dat(dat_c),
        .o_vld(vld_c), .o_dat(out_c), .o_ovf(ovf_c));

    always @(posedge clk) begin
        if (vld_a) cnt_a <= cnt_a + 1;
        if (vld_b) cnt_b <= cnt_b + 1;
        if (vld_c) cnt_c <= cnt_c + 1;
    end

    function automatic int pulses(input int u);
        return (u == 0) ? cnt_a : (u == 1) ? cnt_b : cnt_c;
    endfunction

    // One product, then idle long enough for the FSM to fold it.
    task automatic push(input int u, input logic [25:0] d);
        @(posedge clk); #1;
        case (u)
            0: begin req_a = 1'b1; dat_a = d; end
            1: begin req_b = 1'b1; dat_b = d; end
            default: begin req_c = 1'b1; dat_c = d; end
        endcase
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic wait_pulses(input int u, input int target, input string name);
        int n;
        n = 0;
        while (pulses(u) < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (pulses(u) < target) begin
            tests++; fails++;
            $display("FAIL %s: timeout, pulses %0d, required %0d", name, pulses(u), target);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        tests++; if ({vld_a, ovf_a, out_a} !== 28'h0) begin fails++;
            $display("FAIL reset_a: got vld=%b ovf=%b dat=%h, required 0", vld_a, ovf_a, out_a); end
        tests++; if ({vld_b, ovf_b, out_b} !== 28'h0) begin fails++;
            $display("FAIL reset_b: got vld=%b ovf=%b dat=%h, required 0", vld_b, ovf_b, out_b); end
        rst = 1'b1;
        @(posedge clk); #1;
        tests++; if ({vld_c, ovf_c, out_c} !== 28'h0) begin fails++;
            $display("FAIL reset_c: got vld=%b ovf=%b dat=%h, required 0", vld_c, ovf_c, out_c); end
    endtask

    task automatic test_sum_ones;
        for (int i = 0; i < 4; i++) push(0, ONE);
        wait_pulses(0, 1, "sum_ones");
        tests++; if (out_a !== 26'h1020000) begin fails++;
            $display("FAIL sum_ones: got %h, required 1020000", out_a); end
        repeat (20) @(posedge clk);
        #1;
        tests++; if (cnt_a !== 1) begin fails++;
            $display("FAIL sum_ones_pulses: got %0d, required 1", cnt_a); end
    endtask

    task automatic test_cancel;
        push(1, ONE);
        push(1, MONE);
        wait_pulses(1, 1, "cancel");
        tests++; if (out_b !== 26'h0000000) begin fails++;
            $display("FAIL cancel: got %h, required 0000000", out_b); end
    endtask

    task automatic test_zero_operand;
        push(1, 26'h1010000);
        push(1, 26'h0000000);
        wait_pulses(1, 2, "zero_op");
        tests++; if (out_b !== 26'h1010000) begin fails++;
            $display("FAIL zero_op: got %h, required 1010000", out_b); end
        push(1, 26'h1000000);
        push(1, ONE);
        wait_pulses(1, 3, "two_plus_one");
        tests++; if (out_b !== 26'h1010000) begin fails++;
            $display("FAIL two_plus_one: got %h, required 1010000", out_b); end
    endtask

    task automatic test_saturate;
        push(1, 26'h1FDFFFF);
        push(1, 26'h1FDFFFF);
        wait_pulses(1, 4, "saturate");
        tests++; if (out_b !== 26'h1FDFFFF) begin fails++;
            $display("FAIL saturate: got %h, required 1fdffff", out_b); end
        tests++; if (ovf_b !== 1'b0) begin fails++;
            $display("FAIL saturate_ovf: got %b, required 0", ovf_b); end
        push(1, MONE);
        push(1, MONE);
        wait_pulses(1, 5, "neg_sum");
        tests++; if (out_b !== 26'h3000000) begin fails++;
            $display("FAIL neg_sum: got %h, required 3000000", out_b); end
    endtask

    // Depth-4 FIFO against a 4-cycle fold: 7 of the 12 burst samples are accepted.
    task automatic test_overflow;
        tests++; if (ovf_c !== 1'b0) begin fails++;
            $display("FAIL ovf_pre: got %b, required 0", ovf_c); end
        @(posedge clk); #1;
        req_c = 1'b1; dat_c = ONE;
        repeat (12) @(posedge clk);
        #1;
        req_c = 1'b0;
        tests++; if (ovf_c !== 1'b1) begin fails++;
            $display("FAIL ovf_set: got %b, required 1", ovf_c); end
        repeat (40) @(posedge clk);
        #1;
        tests++; if (cnt_c !== 0) begin fails++;
            $display("FAIL ovf_early_pulse: got %0d pulses, required 0", cnt_c); end
        for (int i = 0; i < 9; i++) push(2, ONE);
        wait_pulses(2, 1, "ovf_sum");
        tests++; if (out_c !== 26'h1060000) begin fails++;
            $display("FAIL ovf_sum: got %h, required 1060000", out_c); end
        tests++; if (ovf_c !== 1'b1) begin fails++;
            $display("FAIL ovf_sticky: got %b, required 1", ovf_c); end
    endtask

    task automatic test_reset_mid_group;
        int c0;
        push(0, ONE);
        push(0, ONE);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests++; if ({vld_a, ovf_a, out_a} !== 28'h0) begin fails++;
            $display("FAIL mid_reset_a: got vld=%b ovf=%b dat=%h, required 0", vld_a, ovf_a, out_a); end
        tests++; if ({ovf_c, out_c} !== 27'h0) begin fails++;
            $display("FAIL mid_reset_c: got ovf=%b dat=%h, required 0", ovf_c, out_c); end
        @(posedge clk); #1;
        rst = 1'b1;
        c0 = cnt_a;
        repeat (20) @(posedge clk);
        #1;
        tests++; if (cnt_a !== c0) begin fails++;
            $display("FAIL mid_reset_pulse: got %0d pulses, required %0d", cnt_a, c0); end
        for (int i = 0; i < 4; i++) push(0, ONE);
        wait_pulses(0, c0 + 1, "fresh_group");
        tests++; if (out_a !== 26'h1020000) begin fails++;
            $display("FAIL fresh_group: got %h, required 1020000", out_a); end
    endtask

    initial begin
        test_reset;
        test_sum_ones;
        test_cancel;
        test_zero_operand;
        test_saturate;
        test_overflow;
        test_reset_mid_group;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sfp_acc.md
Name: sfp_acc

Overview:
- Streaming floating-point accumulator placed directly downstream of sfp_mult; consumes its o_vld/o_do product stream.
- Sums LEN consecutive products, as in a dot product, and emits one slf-format result per group.
- The result feeds sfp_slf2std for conversion back to IEEE-754 single.
- Internally: an input FIFO absorbs burst products, then a multi-cycle align/add/normalize FSM folds each product into the accumulator.

Parameters:
- LEN, 16: products per accumulation group (>=1).
- FIFO_AW, 4: input FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  product valid; connects to sfp_mult o_vld.
- i_dat  in  26  product in slf format; connects to sfp_mult o_do.
- o_vld  out  1  one-cycle pulse, group sum valid.
- o_dat  out  26  group sum in slf format.
- o_ovf  out  1  sticky: input arrived while FIFO full.

Behaviour:
- slf format: [25] sign, [24:17] exponent with bias 127, [16:0] fraction with hidden leading 1.
  - exp==0 encodes zero; the fraction is ignored. No denormals, inf or NaN.
- Reset (rst low, async): o_vld=0, o_dat=0, o_ovf=0, FIFO empty, accumulator=+0, element count=0, FSM=IDLE.
- FIFO:
  - Write when i_req=1 and not full.
  - i_req=1 while full drops the sample and sets o_ovf, which stays set until reset.
  - Simultaneous write and pop is allowed at any fill level, including full: pop frees the slot the same cycle.
- FSM:
  - IDLE: pop when FIFO non-empty -> ALIGN.
  - ALIGN: compare exponents; right-shift the smaller mantissa (hidden bit plus 3 guard bits) by the difference; shifts >=21 yield 0 -> ADD.
  - ADD: add or subtract magnitudes by sign; result sign follows the larger magnitude -> NORM.
  - NORM:
    - Leading-one detect, shift, adjust exponent, truncate guard bits.
    - Write the accumulator and increment count.
    - If count reaches LEN: assert o_vld for 1 cycle with o_dat = result, clear accumulator to +0, set count to 0.
    - -> IDLE.
- Throughput: one product per 4 cycles (IDLE/ALIGN/ADD/NORM). Latency from FIFO pop to o_vld is 3 cycles for the last element of a group.
- Zero operand: result equals the other operand exactly.
- Exact cancellation: result is +0 (exp=0, sign=0).
- Exponent overflow (>254): saturate to signed max finite: exp=254, frac=all ones.
- Exponent underflow (<1 after normalisation): flush to +0.
- o_dat holds its last value between pulses.
- Reset mid-group: the partial sum and FIFO contents are discarded; no o_vld is produced.

Optional Feature:
- Macro: SFP_ACC_RND_EN.
- Defined: NORM applies round-to-nearest-even using the guard/round/sticky bits.
  - A mantissa carry-out re-normalises (exp+1) in the same cycle.
  - Overflow caused by rounding saturates as above.
- Undefined: guard bits are truncated, i.e. round toward zero.
- Cycle timing is identical in both builds.

Decomposition:
- sfp_pkg holds:
  - SFP_W=26, EXP_W=8, FRAC_W=17, BIAS=127, GUARD_W=3.
  - State enum IDLE/ALIGN/ADD/NORM.
  - Constants SFP_ZERO and SFP_MAX_POS/NEG.
- Sub-module sfp_acc_fifo: synchronous FIFO, width 26, depth 2**FIFO_AW, with full/empty flags.
- The FSM and datapath stay in sfp_acc.

Test Plan:
1. LEN=4; push 0x0FE0000 (1.0) four times, 1 per 8 cycles -> single o_vld pulse with o_dat=0x1020000 (4.0).
2. LEN=2; push 0x0FE0000 (1.0) then 0x2FE0000 (-1.0) -> o_dat=0x0000000 (+0).
3. LEN=2; push 0x1010000 (3.0) then 0x0000000 (zero) -> o_dat=0x1010000. Then push 0x1000000 (2.0) and 0x0FE0000 (1.0) -> second pulse, o_dat=0x1010000.
4. LEN=2; push 0x1FDFFFF (max finite) twice -> o_dat=0x1FDFFFF (saturated), o_ovf=0.
5. FIFO_AW=2, LEN=16; drive i_req=1 with 1.0 for 12 consecutive cycles -> o_ovf rises on the first write while full and stays 1; only accepted samples are summed.
6. Assert rst low for 1 cycle after 2 of 4 products -> all outputs 0, no o_vld. Then 4 fresh 1.0 inputs -> o_dat=0x1020000.
